servo_pwm_array: RTL

Parametrised multi-channel servo PWM generator that drives NUM_CH valve servos from one shared frame counter (20 ms frame by default). Angle commands arrive over a valid/ready handshake and are stored per channel as target widths. Active pulse widths change only at frame boundaries and ramp toward the target at a programmable slew rate, so valve actuation cannot produce glitched pulses or abrupt jumps. This block replaces single-channel, fixed-angle servo drive in the flow-control top level.

---
 rtl/servo_pwm_array.sv | 109 ++++++++++
 1 files changed

// File: rtl/servo_pwm_array.sv
// Multi-channel servo PWM generator sharing one frame counter.
// Commanded angles become target widths; active widths follow them only at frame boundaries.
module servo_pwm_array #(
  parameter int NUM_CH     = 4,
  parameter int PERIOD_CYC = 2000000,
  parameter int MIN_PULSE  = 100000,
  parameter int MAX_PULSE  = 200000,
  parameter int ANGLE_W    = 8,
  parameter int ANGLE_UNIT = 392,
  parameter int SLEW_STEP  = 0,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W      = $clog2(PERIOD_CYC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CH-1:0]  ch_en,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CH_W-1:0]    cmd_ch,
  input  logic [ANGLE_W-1:0] cmd_angle,
  output logic               cmd_err,
  output logic [NUM_CH-1:0]  pwm,
  output logic [NUM_CH-1:0]  busy,
  output logic               frame_tick
);

  localparam int WIDE_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0]  SLEW_CNT = CNT_W'(SLEW_STEP);
  localparam logic [WIDE_W-1:0] MIN_WIDE = WIDE_W'(MIN_PULSE);
  localparam logic [WIDE_W-1:0] MAX_WIDE = WIDE_W'(MAX_PULSE);
  localparam logic [WIDE_W-1:0] UNIT_WIDE = WIDE_W'(ANGLE_UNIT);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  target     [NUM_CH];
  logic [CNT_W-1:0]  active     [NUM_CH];
  logic [CNT_W-1:0]  target_nxt [NUM_CH];
  logic [CNT_W-1:0]  active_nxt [NUM_CH];
  logic              frame_end;
  logic              accept;
  logic              ch_legal;
  logic [WIDE_W-1:0] raw_width;
  logic [CNT_W-1:0]  cmd_width;

  // The last cycle of the frame is reserved for moving active widths, so commands wait.
  assign frame_end = (count == LAST_CNT);
  assign cmd_ready = rst_n && !frame_end;
  assign accept    = cmd_valid && cmd_ready;
  assign ch_legal  = (int'(cmd_ch) < NUM_CH);

  assign raw_width = MIN_WIDE + WIDE_W'(cmd_angle) * UNIT_WIDE;
  assign cmd_width = (raw_width > MAX_WIDE) ? MAX_CNT : raw_width[CNT_W-1:0];

  function automatic logic [CNT_W-1:0] step_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] diff;
    diff = '0;
    if (SLEW_STEP == 0) begin
      return tgt;
    end
    if (tgt > cur) begin
      diff = tgt - cur;
      return (diff > SLEW_CNT) ? cur + SLEW_CNT : tgt;
    end
    diff = cur - tgt;
    return (diff > SLEW_CNT) ? cur - SLEW_CNT : tgt;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      target_nxt[i] = target[i];
      active_nxt[i] = active[i];
      if (accept && ch_legal && (int'(cmd_ch) == i)) begin
        target_nxt[i] = cmd_width;
      end
      if (frame_end) begin
        active_nxt[i] = step_toward(active[i], target[i]);
      end
    end
  end

  // pwm compares the previous-cycle count, so every pulse rises one cycle after count==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      pwm        <= '0;
      busy       <= '0;
      frame_tick <= 1'b0;
      cmd_err    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= MIN_CNT;
        active[i] <= MIN_CNT;
      end
    end else begin
      count      <= frame_end ? '0 : count + CNT_W'(1);
      frame_tick <= (count == '0);
      cmd_err    <= accept && !ch_legal;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= target_nxt[i];
        active[i] <= active_nxt[i];
        busy[i]   <= (active_nxt[i] != target_nxt[i]);
        pwm[i]    <= ch_en[i] && (count < active[i]);
      end
    end
  end

endmodule
